// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// rle_pkg : shared types and helpers for the run-length encoder
// Rev 1.0 : initial release
// ============================================================================
package rle_pkg;

  localparam int RLE_SDW = 32;

  typedef enum logic {
    TAG_DATA = 1'b0,
    TAG_CNT  = 1'b1
  } rle_tag_e;

  // Tagged output word at the default sample width.
  typedef struct packed {
    rle_tag_e             tag;
    logic [RLE_SDW-1:0]   payload;
  } rle_word_t;

  function automatic logic [63:0] rle_cmax(input int rcw);
    return (64'd1 << rcw) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/str_reg.sv
`default_nettype none
// ============================================================================
// str_reg : single-entry registered stream stage with load/free interface
// Rev 1.0 : initial release
// ============================================================================
module str_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         free,
  output logic [W-1:0] dout,
  output logic         dvalid,
  input  logic         dready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign free   = !r_valid || dready;
  assign dout   = r_data;
  assign dvalid = r_valid;

  // A load is only honoured when the stage is free, so held data never changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (free) begin
      r_valid <= load;
      if (load) begin
        r_data <= din;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rle_enc.sv
`default_nettype none
// ============================================================================
// rle_enc : run-length encoder (data word on first value, count word on repeats)
// Rev 1.0 : initial release
// ============================================================================
module rle_enc
  import rle_pkg::*;
#(
  parameter int SDW = 32,
  parameter int RCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_ena,
  input  logic           flush,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sti_tvalid,
  output logic           sti_tready,
  output logic [SDW:0]   sto_tdata,
  output logic           sto_tvalid,
  input  logic           sto_tready
);

  localparam logic [RCW-1:0] CMAX = RCW'(rle_cmax(RCW));

  logic           w_free;
  logic           w_accept;
  logic           w_load;
  logic [SDW:0]   w_word;

  logic           r_held;
  logic           r_pend;
  logic [SDW-1:0] r_val;
  logic [RCW-1:0] r_cnt;

  logic           w_held_nx;
  logic           w_pend_nx;
  logic [SDW-1:0] w_val_nx;
  logic [RCW-1:0] w_cnt_nx;

  assign sti_tready = !rst && w_free && !r_pend && !flush;
  assign w_accept   = sti_tvalid && sti_tready;

  // Priority: owed data word, then flush, then the incoming sample.
  always_comb begin
    w_load    = 1'b0;
    w_word    = '0;
    w_held_nx = r_held;
    w_pend_nx = r_pend;
    w_val_nx  = r_val;
    w_cnt_nx  = r_cnt;
    if (!cfg_ena) begin
      if (w_accept) begin
        w_load = 1'b1;
        w_word = {TAG_DATA, sti_tdata};
      end
    end else if (r_pend) begin
      if (w_free) begin
        w_load    = 1'b1;
        w_word    = {TAG_DATA, r_val};
        w_pend_nx = 1'b0;
      end
    end else if (flush) begin
      if (w_free && r_held) begin
        if (r_cnt != '0) begin
          w_load = 1'b1;
          w_word = {TAG_CNT, SDW'(r_cnt)};
        end
        w_cnt_nx  = '0;
        w_held_nx = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_held) begin
        w_load    = 1'b1;
        w_word    = {TAG_DATA, sti_tdata};
        w_held_nx = 1'b1;
        w_val_nx  = sti_tdata;
        w_cnt_nx  = '0;
      end else if (sti_tdata == r_val) begin
        if (r_cnt != CMAX) begin
          w_cnt_nx = r_cnt + 1'b1;
        end else begin
          // Saturated run: emit the full count, this sample starts the next one.
          w_load   = 1'b1;
          w_word   = {TAG_CNT, SDW'(CMAX)};
          w_cnt_nx = RCW'(1);
        end
      end else if (r_cnt == '0) begin
        w_load   = 1'b1;
        w_word   = {TAG_DATA, sti_tdata};
        w_val_nx = sti_tdata;
      end else begin
        w_load    = 1'b1;
        w_word    = {TAG_CNT, SDW'(r_cnt)};
        w_val_nx  = sti_tdata;
        w_cnt_nx  = '0;
        w_pend_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 1'b0;
      r_pend <= 1'b0;
      r_val  <= '0;
      r_cnt  <= '0;
    end else begin
      r_held <= w_held_nx;
      r_pend <= w_pend_nx;
      r_val  <= w_val_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  str_reg #(
    .W (SDW + 1)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .din    (w_word),
    .free   (w_free),
    .dout   (sto_tdata),
    .dvalid (sto_tvalid),
    .dready (sto_tready)
  );

endmodule
`default_nettype wire

// File: tb/tb_rle_enc.sv
`default_nettype none
// ============================================================================
// tb_rle_enc : directed self-checking bench for rle_enc
// Rev 1.0 : initial release
// ============================================================================
module tb_rle_enc;
  import rle_pkg::*;

  localparam logic [31:0] VA = 32'hA5A5_0001;
  localparam logic [31:0] VB = 32'hA5A5_0002;
  localparam logic [31:0] VC = 32'hA5A5_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_ena = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        use_sat = 1'b0;
  logic        rdy_lvl = 1'b1;
  logic        bp_on = 1'b0;
  logic        bp_phase = 1'b0;
  logic        sto_tready;
  logic        m_tvalid, s_tvalid, m_rdy, s_rdy, m_vld, s_vld, cur_rdy;
  logic [32:0] m_data, s_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] q_m[$];
  logic [32:0] q_s[$];
  logic [32:0] exp_q[$];
  logic        stall_seen = 1'b0;
  logic [32:0] stall_data = '0;

  assign sto_tready = bp_on ? bp_phase : rdy_lvl;
  assign m_tvalid   = tvalid && !use_sat;
  assign s_tvalid   = tvalid && use_sat;
  assign cur_rdy    = use_sat ? s_rdy : m_rdy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bp_phase = ~bp_phase;
  end

  rle_enc #(.SDW(32), .RCW(16)) u_dut (
    .clk (clk), .rst (rst), .cfg_ena (cfg_ena), .flush (flush),
    .sti_tdata (tdata), .sti_tvalid (m_tvalid), .sti_tready (m_rdy),
    .sto_tdata (m_data), .sto_tvalid (m_vld), .sto_tready (sto_tready)
  );

  rle_enc #(.SDW(32), .RCW(4)) u_sat (
    .clk (clk), .rst (rst), .cfg_ena (cfg_ena), .flush (flush),
    .sti_tdata (tdata), .sti_tvalid (s_tvalid), .sti_tready (s_rdy),
    .sto_tdata (s_data), .sto_tvalid (s_vld), .sto_tready (sto_tready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [32:0] dw(input logic [31:0] v);
    rle_word_t w;
    w.tag = TAG_DATA;
    w.payload = v;
    return w;
  endfunction

  function automatic logic [32:0] cw(input logic [31:0] n);
    rle_word_t w;
    w.tag = TAG_CNT;
    w.payload = n;
    return w;
  endfunction

  // Output collector plus stall-stability watch on the main instance.
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_vld", 64'(m_vld), 64'd1);
        check("stall_data", 64'(m_data), 64'(stall_data));
      end
      if (m_vld && sto_tready) q_m.push_back(m_data);
      if (s_vld && sto_tready) q_s.push_back(s_data);
      stall_seen = m_vld && !sto_tready;
      stall_data = m_data;
    end
  end

  task automatic send(input logic [31:0] v);
    int n = 0;
    tdata  = v;
    tvalid = 1'b1;
    @(negedge clk);
    while (!cur_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_rdy) check("send_timeout", 64'(cur_rdy), 64'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_rdy", 64'(cur_rdy), 64'd0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input bit sat);
    logic [32:0] got[$];
    if (sat) got = q_s;
    else got = q_m;
    check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < got.size()) ? 64'(got[i]) : {64{1'bx}}, 64'(exp_q[i]));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 64'(m_vld), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_rdy", 64'(m_rdy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass-through: each sample appears one cycle after its transfer
    for (int i = 0; i < 8; i++) begin
      tdata  = 32'(i);
      tvalid = 1'b1;
      @(negedge clk);
      check("pt_rdy", 64'(m_rdy), 64'd1);
      @(posedge clk);
      #1;
      check("pt_vld", 64'(m_vld), 64'd1);
      check("pt_data", 64'(m_data), 64'(dw(32'(i))));
    end
    tvalid = 1'b0;
    idle(3);
    cfg_ena = 1'b1;

    // A,A,A,A,B then flush
    q_m.delete();
    for (int i = 0; i < 4; i++) send(VA);
    send(VB);
    @(negedge clk);
    check("pend_rdy_lo", 64'(m_rdy), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pend_rdy_hi", 64'(m_rdy), 64'd1);
    @(posedge clk);
    #1;
    do_flush();
    idle(4);
    exp_q.delete();
    exp_q.push_back(dw(VA)); exp_q.push_back(cw(3)); exp_q.push_back(dw(VB));
    check_q("rle_basic", 1'b0);

    // Saturation on the RCW=4 instance
    use_sat = 1'b1;
    q_s.delete();
    for (int i = 0; i < 20; i++) send(32'd5);
    do_flush();
    use_sat = 1'b0;
    idle(4);
    exp_q.delete();
    exp_q.push_back(dw(5)); exp_q.push_back(cw(15)); exp_q.push_back(cw(4));
    check_q("sat", 1'b1);

    // Backpressure toggling every cycle
    q_m.delete();
    bp_on = 1'b1;
    send(VA); send(VA); send(VB); send(VC); send(VC); send(VC);
    do_flush();
    idle(6);
    bp_on = 1'b0;
    idle(4);
    exp_q.delete();
    exp_q.push_back(dw(VA)); exp_q.push_back(cw(1)); exp_q.push_back(dw(VB));
    exp_q.push_back(dw(VC)); exp_q.push_back(cw(2));
    check_q("bp", 1'b0);

    // Flush arriving with a differing sample while a data word is owed
    q_m.delete();
    send(VA); send(VA); send(VB);
    flush  = 1'b1;
    tdata  = VC;
    tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("fp_hold", 64'(m_rdy), 64'd0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    send(VC);
    idle(4);
    exp_q.delete();
    exp_q.push_back(dw(VA)); exp_q.push_back(cw(1)); exp_q.push_back(dw(VB));
    exp_q.push_back(dw(VC));
    check_q("flush_prio", 1'b0);

    // Reset mid-run with a count word stalled on the output
    for (int i = 0; i < 8; i++) send(VA);
    rdy_lvl = 1'b0;
    send(VB);
    check("mid_vld", 64'(m_vld), 64'd1);
    check("mid_data", 64'(m_data), 64'(cw(7)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_vld", 64'(m_vld), 64'd0);
    check("mrst_rdy", 64'(m_rdy), 64'd0);
    check("mrst_data", 64'(m_data), 64'd0);
    rst = 1'b0;
    rdy_lvl = 1'b1;
    q_m.delete();
    send(VB);
    idle(3);
    exp_q.delete();
    exp_q.push_back(dw(VB));
    check_q("post_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
